// File: rtl/timer_ctrl.sv
// timer_ctrl: run/pause/lap/clear controller driving an hh:mm:ss BCD counter datapath.
// Define DEBOUNCE_EN to insert a DB_CYCLES stability filter behind each key synchroniser.
module timer_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       cnt_max,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_LAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || DB_CYCLES < 1) begin : g_bad_param
        $error("timer_ctrl: TICK_DIV must be >= 2 and DB_CYCLES >= 1");
    end

    // Index 0 is the start key, index 1 the lap key; all key flops idle high.
    logic [1:0] key_n;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] prev_q, prev_d;
    logic [1:0] level;
    logic [1:0] press;
    logic       start_p;
    logic       lap_p;

    assign key_n = {key_lap_n, key_start_n};

`ifdef DEBOUNCE_EN
    localparam int            DW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    logic [1:0]    flt_q, flt_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    // The filtered level flips only after the synced level differs for DB_CYCLES edges in a row.
    always_comb begin
        flt_d = flt_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != flt_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    flt_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            flt_q <= flt_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign level = flt_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    assign press   = prev_q & ~level;
    assign start_p = press[0];
    assign lap_p   = press[1];

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          counting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority everywhere: cnt_max, then start, then lap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_p) state_d = S_RUN;
            end
            S_RUN, S_LAP: begin
                if (cnt_max)      state_d = S_DONE;
                else if (start_p) state_d = S_PAUSE;
                else if (lap_p)   state_d = (state_q == S_RUN) ? S_LAP : S_RUN;
            end
            S_PAUSE: begin
                if (start_p)    state_d = S_RUN;
                else if (lap_p) state_d = S_IDLE;
            end
            S_DONE: begin
                if (lap_p) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Prescaler keeps its phase across PAUSE so a resumed second is not lost.
    always_comb begin
        counting = (state_q == S_RUN) || (state_q == S_LAP);
        presc_d  = '0;
        if (counting) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end else if (state_q == S_PAUSE) begin
            presc_d = presc_q;
        end
        cnt_en_d  = counting && (presc_q == PRESC_LAST) && !cnt_max;
        cnt_clr_d = lap_p && ((state_q == S_DONE) ||
                              (!start_p && ((state_q == S_IDLE) || (state_q == S_PAUSE))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            prev_q    <= 2'b11;
            presc_q   <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            presc_q   <= presc_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign disp_hold = (state_q == S_LAP);
    assign state     = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed key/cnt_max schedule with an event scoreboard.
// Event records pack {cycle, kind, state, disp_hold}; a negedge monitor pops and compares.
module tb_timer_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
`ifdef DEBOUNCE_EN
    localparam int LAT  = 3 + DB_CYCLES;
    localparam int HOLD = DB_CYCLES + 2;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
`endif
    localparam int W = 22;
    localparam logic [1:0] K_ST  = 2'd0;
    localparam logic [1:0] K_EN  = 2'd1;
    localparam logic [1:0] K_CLR = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start_n = 1'b1;
    logic       key_lap_n = 1'b1;
    logic       cnt_max = 1'b0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       disp_hold;
    logic [2:0] state;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_state = 3'd0;
    logic [W-1:0] exp_q[$];

    timer_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk(clk), .rst(rst), .key_start_n(key_start_n), .key_lap_n(key_lap_n),
        .cnt_max(cnt_max), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .disp_hold(disp_hold), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input int c, input logic [1:0] k, input logic [2:0] s);
        exp_q.push_back({16'(c), k, s, (s == 3'd3)});
    endtask

    task automatic check_ev(input logic [1:0] k);
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        obs = {16'(cyc), k, state, disp_hold};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got cyc=%0d kind=%0d state=%0d hold=%0b, required no event",
                     cyc, k, state, disp_hold);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                errors++;
                $display("FAIL event: got cyc=%0d kind=%0d state=%0d hold=%0b, required cyc=%0d kind=%0d state=%0d hold=%0b",
                         obs[W-1:6], obs[5:4], obs[3:1], obs[0], exp[W-1:6], exp[5:4], exp[3:1], exp[0]);
            end
        end
    endtask

    // Monitor: every state change, cnt_en strobe and cnt_clr strobe is one event.
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_state = state;
        end else begin
            if (state !== prev_state) check_ev(K_ST);
            if (cnt_en !== 1'b0) check_ev(K_EN);
            if (cnt_clr !== 1'b0) check_ev(K_CLR);
            prev_state = state;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic go(input int c);
        if (cyc > c) begin
            errors++;
            $display("FAIL schedule: cyc=%0d already past required %0d", cyc, c);
        end
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press(input logic s, input logic l);
        if (s) key_start_n = 1'b0;
        if (l) key_lap_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        key_start_n = 1'b1;
        key_lap_n = 1'b1;
    endtask

    int t, e, r, d, x, y;

    initial begin
        // Reset and idle keys
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 8'(state), 8'd0);
        chk("reset_cnt_en", 8'(cnt_en), 8'd0);
        chk("reset_cnt_clr", 8'(cnt_clr), 8'd0);
        chk("reset_disp_hold", 8'(disp_hold), 8'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        go(cyc + 20);

        // Start from IDLE: five strobes at 10-cycle period
        t = cyc + 2;
        go(t);
        e = t + LAT;
        expect_ev(e, K_ST, 3'd1);
        for (int i = 1; i <= 5; i++) expect_ev(e + 10 * i, K_EN, 3'd1);
        press(1'b1, 1'b0);

        // Pause 6 cycles after the fifth strobe, resume after 103 cycles
        go(e + 56 - LAT);
        expect_ev(e + 56, K_ST, 3'd2);
        press(1'b1, 1'b0);
        r = e + 159;
        go(r - LAT);
        expect_ev(r, K_ST, 3'd1);
        expect_ev(r + 4, K_EN, 3'd1);
        press(1'b1, 1'b0);

        // Lap and back to RUN; strobes continue with unchanged phase
        go(r + 9 - LAT);
        expect_ev(r + 9, K_ST, 3'd3);
        expect_ev(r + 14, K_EN, 3'd3);
        expect_ev(r + 24, K_EN, 3'd3);
        press(1'b0, 1'b1);
        go(r + 28 - LAT);
        expect_ev(r + 28, K_ST, 3'd1);
        expect_ev(r + 34, K_EN, 3'd1);
        press(1'b0, 1'b1);

        // cnt_max on the strobe cycle: strobe suppressed, DONE, then lap clears
        go(r + 43);
        cnt_max = 1'b1;
        d = r + 44;
        expect_ev(d, K_ST, 3'd4);
        go(d + 200);
        expect_ev(d + 200 + LAT, K_ST, 3'd0);
        expect_ev(d + 200 + LAT, K_CLR, 3'd0);
        press(1'b0, 1'b1);
        go(d + 201 + LAT);
        cnt_max = 1'b0;

        // Lap in IDLE: clear strobe only
        t = cyc + 10;
        go(t);
        expect_ev(t + LAT, K_CLR, 3'd0);
        press(1'b0, 1'b1);

        // Simultaneous start+lap in RUN -> PAUSE; lap in PAUSE -> IDLE with clear
        t = cyc + 20;
        go(t);
        x = t + LAT;
        expect_ev(x, K_ST, 3'd1);
        press(1'b1, 1'b0);
        go(x + 2);
        expect_ev(x + 2 + LAT, K_ST, 3'd2);
        press(1'b1, 1'b1);
        t = cyc + 20;
        go(t);
        expect_ev(t + LAT, K_ST, 3'd0);
        expect_ev(t + LAT, K_CLR, 3'd0);
        press(1'b0, 1'b1);

        // Reset in RUN
        t = cyc + 20;
        go(t);
        y = t + LAT;
        expect_ev(y, K_ST, 3'd1);
        press(1'b1, 1'b0);
        go(y + 5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", 8'(state), 8'd0);
        chk("midrst_cnt_en", 8'(cnt_en), 8'd0);
        chk("midrst_cnt_clr", 8'(cnt_clr), 8'd0);
        chk("midrst_disp_hold", 8'(disp_hold), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        go(cyc + 20);

        // Press in flight when reset hits is lost
        key_start_n = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        key_start_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        go(cyc + 20);

`ifdef DEBOUNCE_EN
        // Short glitch is filtered out
        t = cyc + 10;
        go(t);
        key_start_n = 1'b0;
        repeat (3) @(negedge clk);
        key_start_n = 1'b1;
        go(cyc + 30);
`endif

        go(cyc + 5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
